// File: rtl/jt12_mix_pkg.sv
// Shared types for the jt12 channel mixer: FSM state encoding and the
// accumulator width helper used to size the MAC datapath.
package jt12_mix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } mix_state_t;

    // Headroom for chn full-scale products of signed(inw) x unsigned(gainw)
    function automatic int mix_accw(input int inw, input int gainw, input int chn);
        return inw + gainw + 1 + $clog2(chn);
    endfunction

endpackage

// File: rtl/jt12_mix_sat.sv
// Combinational fixed-point scaler: arithmetic right shift by gfrac (floor),
// then saturation from accw bits to outw bits; over flags a clamped result.
module jt12_mix_sat #(
    parameter int accw  = 27,
    parameter int outw  = 16,
    parameter int gfrac = 4
) (
    input  logic signed [accw-1:0] acc,
    output logic signed [outw-1:0] y,
    output logic                   over
);

    logic signed [accw-1:0] r;

    // Shift then clamp whenever the bits above the output sign differ from it
    always_comb begin
        r    = acc >>> gfrac;
        over = 1'b0;
        y    = r[outw-1:0];
        if (r[accw-1:outw-1] != {(accw-outw+1){r[accw-1]}}) begin
            over = 1'b1;
            if (r[accw-1]) begin
                y = {1'b1, {(outw-1){1'b0}}};
            end else begin
                y = {1'b0, {(outw-1){1'b1}}};
            end
        end else begin
            over = 1'b0;
            y    = r[outw-1:0];
        end
    end

endmodule

// File: rtl/jt12_chmix.sv
// Time-multiplexed weighted channel mixer: snapshot on cen_in, one MAC per
// clock, saturated output. Optional sticky clip flag under JT12_MIX_CLIP_EN.
module jt12_chmix
    import jt12_mix_pkg::*;
#(
    parameter int inw   = 16,
    parameter int chn   = 4,
    parameter int gainw = 8,
    parameter int gfrac = 4,
    parameter int outw  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cen_in,
    input  logic [chn*inw-1:0]      ch_in,
    input  logic [chn*gainw-1:0]    gain,
    input  logic [chn-1:0]          ch_en,
    output logic signed [outw-1:0]  snd_out,
    output logic                    valid,
    output logic                    busy
`ifdef JT12_MIX_CLIP_EN
    ,
    output logic                    clip,
    input  logic                    clip_clr
`endif
);

    localparam int accw = mix_accw(inw, gainw, chn);
    localparam int iw   = $clog2(chn);
    localparam int pw   = inw + gainw + 1;

    mix_state_t state, next_state;

    logic [chn*inw-1:0]      ch_s;
    logic [chn*gainw-1:0]    gain_s;
    logic [chn-1:0]          ch_en_s;
    logic signed [accw-1:0]  acc;
    logic [iw-1:0]           idx;

    logic signed [inw-1:0]   cur_ch;
    logic [gainw-1:0]        cur_gain;
    logic                    cur_en;
    logic signed [pw-1:0]    prod;
    logic signed [outw-1:0]  sat_y;
    logic                    sat_over;

    // Select the current channel and form its product; gain is treated as a positive signed value
    always_comb begin
        cur_ch   = ch_s[int'(idx)*inw +: inw];
        cur_gain = gain_s[int'(idx)*gainw +: gainw];
        cur_en   = ch_en_s[idx];
        if (cur_en) begin
            prod = pw'(cur_ch) * pw'($signed({1'b0, cur_gain}));
        end else begin
            prod = {pw{1'b0}};
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (cen_in) begin
                    next_state = ST_MAC;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (idx == iw'(chn-1)) begin
                    next_state = ST_OUT;
                end else begin
                    next_state = ST_MAC;
                end
            end
            ST_OUT:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Snapshot registers, accumulator and channel index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_s    <= {(chn*inw){1'b0}};
            gain_s  <= {(chn*gainw){1'b0}};
            ch_en_s <= {chn{1'b0}};
            acc     <= {accw{1'b0}};
            idx     <= {iw{1'b0}};
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cen_in) begin
                        ch_s    <= ch_in;
                        gain_s  <= gain;
                        ch_en_s <= ch_en;
                        acc     <= {accw{1'b0}};
                        idx     <= {iw{1'b0}};
                    end
                end
                ST_MAC: begin
                    acc <= acc + accw'(prod);
                    idx <= idx + iw'(1);
                end
                default: ;
            endcase
        end
    end

    jt12_mix_sat #(
        .accw  (accw),
        .outw  (outw),
        .gfrac (gfrac)
    ) u_sat (
        .acc  (acc),
        .y    (sat_y),
        .over (sat_over)
    );

    // Registered outputs: busy spans the mix, valid pulses after the OUT edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snd_out <= {outw{1'b0}};
            valid   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cen_in) begin
                        busy <= 1'b1;
                    end
                end
                ST_OUT: begin
                    snd_out <= sat_y;
                    valid   <= 1'b1;
                    busy    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef JT12_MIX_CLIP_EN
    // Sticky clip flag; a set on the same edge as a clear takes priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clip <= 1'b0;
        end else if (state == ST_OUT && sat_over) begin
            clip <= 1'b1;
        end else if (clip_clr) begin
            clip <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_jt12_chmix.sv
// Scoreboard bench for jt12_chmix (chn=4): directed mixes push expected
// samples and arrival cycles; a negedge monitor pops and compares on valid.
module tb_jt12_chmix;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cen_in = 1'b0;
    logic [63:0]        ch_in = 64'd0;
    logic [31:0]        gain = 32'd0;
    logic [3:0]         ch_en = 4'd0;
    logic signed [15:0] snd_out;
    logic               valid;
    logic               busy;
`ifdef JT12_MIX_CLIP_EN
    logic               clip;
    logic               clip_clr = 1'b0;
`endif

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    logic prev_valid = 1'b0;

    jt12_chmix dut (
        .clk     (clk),
        .rst     (rst),
        .cen_in  (cen_in),
        .ch_in   (ch_in),
        .gain    (gain),
        .ch_en   (ch_en),
        .snd_out (snd_out),
        .valid   (valid),
        .busy    (busy)
`ifdef JT12_MIX_CLIP_EN
        ,
        .clip    (clip),
        .clip_clr(clip_clr)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Monitor: every valid must match the head of the scoreboard in value and cycle
    always @(negedge clk) begin
        if (!rst && valid) begin
            if (prev_valid) begin
                n_vec++;
                n_bad++;
                $display("FAIL valid_width: valid high for 2 consecutive cycles at cycle %0d", cyc);
            end
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_valid: got snd_out %0d at cycle %0d, expected no output", snd_out, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("snd_out", int'(snd_out), e.val);
                chk("valid_cycle", cyc, e.cyc);
            end
        end
        prev_valid = valid;
    end

    task automatic mix(input int c0, input int c1, input int c2, input int c3,
                       input int g0, input int g1, input int g2, input int g3,
                       input logic [3:0] en, input int expv,
                       input bit scramble, input int extra, input bit extra_ok);
        int c_start;
        @(negedge clk);
        ch_in  = {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
        gain   = {8'(g3), 8'(g2), 8'(g1), 8'(g0)};
        ch_en  = en;
        cen_in = 1'b1;
        @(posedge clk);
        #1;
        c_start = cyc;
        q.push_back('{val: expv, cyc: c_start + 5});
        @(negedge clk);
        cen_in = 1'b0;
        chk("busy_after_strobe", int'(busy), 1);
        if (scramble) begin
            ch_in = ~ch_in;
            gain  = 32'hFFFF_FFFF;
            ch_en = 4'b1111;
        end
        if (extra > 0) begin
            repeat (extra - 1) @(negedge clk);
            cen_in = 1'b1;
            @(posedge clk);
            if (extra_ok) q.push_back('{val: expv, cyc: c_start + extra + 5});
            @(negedge clk);
            cen_in = 1'b0;
        end
        repeat (extra + 8) @(negedge clk);
        chk("busy_idle", int'(busy), 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_snd_out", int'(snd_out), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic unity mix, then saturation and rounding corners
        mix(1000, -300, 0, 0, 16, 16, 16, 16, 4'b1111, 700, 1'b0, 0, 1'b0);
        mix(32767, 32767, 0, 0, 16, 16, 16, 16, 4'b1111, 32767, 1'b0, 0, 1'b0);
`ifdef JT12_MIX_CLIP_EN
        chk("clip_set", int'(clip), 1);
        @(negedge clk);
        chk("clip_sticky", int'(clip), 1);
        clip_clr = 1'b1;
        @(negedge clk);
        clip_clr = 1'b0;
        chk("clip_cleared", int'(clip), 0);
`endif
        mix(-32768, 0, 0, 0, 255, 16, 16, 16, 4'b1111, -32768, 1'b0, 0, 1'b0);
        mix(-32768, 0, 0, 0, 16, 16, 16, 16, 4'b1111, -32768, 1'b0, 0, 1'b0);
`ifdef JT12_MIX_CLIP_EN
        chk("clip_exact_min", int'(clip), 0);
`endif
        mix(5, 0, 0, 0, 8, 16, 16, 16, 4'b1111, 2, 1'b0, 0, 1'b0);
        mix(-5, 0, 0, 0, 8, 16, 16, 16, 4'b1111, -3, 1'b0, 0, 1'b0);
        mix(-1, 0, 0, 0, 1, 0, 0, 0, 4'b1111, -1, 1'b0, 0, 1'b0);
        mix(100, -50, 7, 3, 32, 24, 1, 0, 4'b1111, 125, 1'b0, 0, 1'b0);

        // Channel enables, input changes after snapshot, all disabled
        mix(100, 100, 100, 100, 16, 16, 16, 16, 4'b0101, 200, 1'b0, 0, 1'b0);
        mix(100, 100, 100, 100, 16, 16, 16, 16, 4'b0101, 200, 1'b1, 0, 1'b0);
        mix(1234, 1234, 1234, 1234, 16, 16, 16, 16, 4'b0000, 0, 1'b0, 0, 1'b0);

        // Strobes during a mix: ignored at E2 and at E(chn+1), accepted at E(chn+2)
        mix(10, 20, 30, 40, 16, 16, 16, 16, 4'b1111, 100, 1'b0, 2, 1'b0);
        mix(10, 20, 30, 40, 16, 16, 16, 16, 4'b1111, 100, 1'b0, 5, 1'b0);
        mix(10, 20, 30, 40, 16, 16, 16, 16, 4'b1111, 100, 1'b0, 6, 1'b1);

        // Reset mid-MAC clears outputs at once and discards the mix
        @(negedge clk);
        ch_in  = {16'sd4, 16'sd3, 16'sd2, 16'sd1};
        gain   = {8'd16, 8'd16, 8'd16, 8'd16};
        ch_en  = 4'b1111;
        cen_in = 1'b1;
        @(negedge clk);
        cen_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_snd_out", int'(snd_out), 0);
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        mix(1000, -300, 0, 0, 16, 16, 16, 16, 4'b1111, 700, 1'b0, 0, 1'b0);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Watchdog so the bench always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
